// File: rtl/load_store_unit_if.sv
// Request/response and data-bus interfaces of the load/store unit.
// Request master is the decode stage; bus master is the load/store unit.
interface lsu_req_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [1:0]    req_size;
  logic          req_unsigned;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic          rsp_err;
  logic [DW-1:0] rsp_rdata;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_err, rsp_rdata
  );
  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_err, rsp_rdata
  );
endinterface

interface lsu_mem_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          mem_d_valid;
  logic          mem_d_ready;
  logic          mem_d_we;
  logic [AW-1:0] mem_d_addr;
  logic [3:0]    mem_d_be;
  logic [DW-1:0] mem_d_wdata;
  logic          mem_d_rvalid;
  logic [DW-1:0] mem_d_rdata;

  modport master (
    output mem_d_valid, mem_d_we, mem_d_addr, mem_d_be, mem_d_wdata,
    input  mem_d_ready, mem_d_rvalid, mem_d_rdata
  );
  modport slave (
    input  mem_d_valid, mem_d_we, mem_d_addr, mem_d_be, mem_d_wdata,
    output mem_d_ready, mem_d_rvalid, mem_d_rdata
  );
endinterface

// File: rtl/load_store_unit.sv
// Execute-stage load/store agent: one outstanding access, word-aligned bus
// cycles with byte enables, sign/zero-extended load data, one-cycle response.
module load_store_unit #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic   clk,
  input  logic   rst_n,
  lsu_req_if.slave req,
  lsu_mem_if.master mem
);

  typedef enum logic [1:0] {S_IDLE, S_BUS_REQ, S_WAIT_RD, S_RESP} state_t;

  state_t        r_state, w_state_nxt;
  logic          r_we;
  logic [1:0]    r_size;
  logic          r_unsigned;
  logic [1:0]    r_off;
  logic [AW-1:0] r_addr;
  logic [3:0]    r_be;
  logic [DW-1:0] r_wdata;
  logic          r_rsp_valid;
  logic          r_rsp_err;
  logic [DW-1:0] r_rsp_rdata;
  logic          w_accept;
  logic          w_misalign;
  logic          w_rd_done;

  function automatic logic [3:0] f_be(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   return 4'b0001 << off;
      2'b01:   return off[1] ? 4'b1100 : 4'b0011;
      2'b10:   return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [DW-1:0] f_wdata(input logic [1:0] size, input logic [DW-1:0] wd);
    case (size)
      2'b00:   return {4{wd[7:0]}};
      2'b01:   return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

  function automatic logic [DW-1:0] f_load(input logic [1:0] size, input logic [1:0] off,
                                           input logic uns, input logic [DW-1:0] word);
    logic        [DW-1:0] sh;
    logic signed [7:0]    b8;
    logic signed [15:0]   h16;
    logic signed [DW-1:0] ext;
    sh  = word >> {off, 3'b000};
    b8  = sh[7:0];
    h16 = sh[15:0];
    case (size)
      2'b00:   ext = uns ? DW'({24'd0, sh[7:0]})  : DW'(b8);
      2'b01:   ext = uns ? DW'({16'd0, sh[15:0]}) : DW'(h16);
      default: ext = word;
    endcase
    return ext;
  endfunction

  assign w_accept   = req.req_valid && (r_state == S_IDLE);
  assign w_misalign = (req.req_size == 2'b11) ||
                      (req.req_size == 2'b01 && req.req_addr[0]) ||
                      (req.req_size == 2'b10 && (req.req_addr[1:0] != 2'b00));
  // Read data is only honoured once the address phase has completed.
  assign w_rd_done  = (r_state == S_WAIT_RD) && mem.mem_d_rvalid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (w_accept) w_state_nxt = w_misalign ? S_RESP : S_BUS_REQ;
      S_BUS_REQ: if (mem.mem_d_ready) w_state_nxt = r_we ? S_RESP : S_WAIT_RD;
      S_WAIT_RD: if (mem.mem_d_rvalid) w_state_nxt = S_RESP;
      S_RESP:    w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // Request capture: bus-side fields are formatted once at accept time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we       <= 1'b0;
      r_size     <= 2'b00;
      r_unsigned <= 1'b0;
      r_off      <= 2'b00;
      r_addr     <= '0;
      r_be       <= 4'b0000;
      r_wdata    <= '0;
    end else if (w_accept) begin
      r_we       <= req.req_we;
      r_size     <= req.req_size;
      r_unsigned <= req.req_unsigned;
      r_off      <= req.req_addr[1:0];
      r_addr     <= {req.req_addr[AW-1:2], 2'b00};
      r_be       <= f_be(req.req_size, req.req_addr[1:0]);
      r_wdata    <= f_wdata(req.req_size, req.req_wdata);
    end
  end

  // Response stage: fields are valid only during the single RESP cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_rsp_valid <= (w_state_nxt == S_RESP);
      r_rsp_err   <= (r_state == S_IDLE) && (w_state_nxt == S_RESP);
      r_rsp_rdata <= w_rd_done ? f_load(r_size, r_off, r_unsigned, mem.mem_d_rdata) : '0;
    end
  end

  assign req.req_ready   = (r_state == S_IDLE);
  assign req.rsp_valid   = r_rsp_valid;
  assign req.rsp_err     = r_rsp_err;
  assign req.rsp_rdata   = r_rsp_rdata;
  assign mem.mem_d_valid = (r_state == S_BUS_REQ);
  assign mem.mem_d_we    = r_we;
  assign mem.mem_d_addr  = r_addr;
  assign mem.mem_d_be    = r_be;
  assign mem.mem_d_wdata = r_wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with hand-computed expectations.
module tb_load_store_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  lsu_req_if #(.AW(32), .DW(32)) u_req ();
  lsu_mem_if #(.AW(32), .DW(32)) u_mem ();

  load_store_unit #(.AW(32), .DW(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (u_req.slave),
    .mem   (u_mem.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one request for one cycle; returns in the cycle after accept.
  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd);
    u_req.req_valid    = 1'b1;
    u_req.req_we       = we;
    u_req.req_size     = size;
    u_req.req_unsigned = uns;
    u_req.req_addr     = addr;
    u_req.req_wdata    = wd;
    tick();
    u_req.req_valid    = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, 32'(u_req.req_ready), 32'd1);
    chk({tag, "_rsp_valid"}, 32'(u_req.rsp_valid), 32'd0);
    chk({tag, "_rsp_err"},   32'(u_req.rsp_err),   32'd0);
    chk({tag, "_rsp_rdata"}, u_req.rsp_rdata,      32'd0);
    chk({tag, "_mvalid"},    32'(u_mem.mem_d_valid), 32'd0);
    chk({tag, "_mwe"},       32'(u_mem.mem_d_we),  32'd0);
    chk({tag, "_mbe"},       32'(u_mem.mem_d_be),  32'd0);
    chk({tag, "_maddr"},     u_mem.mem_d_addr,     32'd0);
    chk({tag, "_mwdata"},    u_mem.mem_d_wdata,    32'd0);
  endtask

  // Load with read data arriving `lat` cycles after the bus accept cycle.
  task automatic do_load(input string tag, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] rdata,
                         input int lat, input logic [3:0] exp_be, input logic [31:0] exp);
    u_mem.mem_d_ready = 1'b1;
    issue(1'b0, size, uns, addr, 32'h0);
    chk({tag, "_mvalid"}, 32'(u_mem.mem_d_valid), 32'd1);
    chk({tag, "_mbe"},    32'(u_mem.mem_d_be), 32'(exp_be));
    chk({tag, "_maddr"},  u_mem.mem_d_addr, {addr[31:2], 2'b00});
    // Stray read data during the accept cycle must be ignored.
    u_mem.mem_d_rvalid = 1'b1;
    u_mem.mem_d_rdata  = 32'h11111111;
    tick();
    u_mem.mem_d_rvalid = 1'b0;
    u_mem.mem_d_rdata  = rdata;
    for (int i = 1; i < lat; i++) begin
      chk({tag, "_wait_rsp"}, 32'(u_req.rsp_valid), 32'd0);
      tick();
    end
    u_mem.mem_d_rvalid = 1'b1;
    tick();
    u_mem.mem_d_rvalid = 1'b0;
    chk({tag, "_rsp_valid"}, 32'(u_req.rsp_valid), 32'd1);
    chk({tag, "_rsp_err"},   32'(u_req.rsp_err),   32'd0);
    chk({tag, "_rdata"},     u_req.rsp_rdata,      exp);
    tick();
    chk({tag, "_ready_back"}, 32'(u_req.req_ready), 32'd1);
    chk({tag, "_rsp_drop"},   32'(u_req.rsp_valid), 32'd0);
  endtask

  task automatic do_err(input string tag, input logic [1:0] size, input logic [31:0] addr);
    u_mem.mem_d_ready = 1'b1;
    issue(1'b0, size, 1'b0, addr, 32'h0);
    chk({tag, "_rsp_valid"}, 32'(u_req.rsp_valid), 32'd1);
    chk({tag, "_rsp_err"},   32'(u_req.rsp_err),   32'd1);
    chk({tag, "_rdata"},     u_req.rsp_rdata,      32'd0);
    chk({tag, "_mvalid"},    32'(u_mem.mem_d_valid), 32'd0);
    tick();
    chk({tag, "_err_drop"},  32'(u_req.rsp_err),   32'd0);
    chk({tag, "_ready"},     32'(u_req.req_ready), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    u_req.req_valid = 1'b0; u_req.req_we = 1'b0; u_req.req_size = 2'b00;
    u_req.req_unsigned = 1'b0; u_req.req_addr = 32'h0; u_req.req_wdata = 32'h0;
    u_mem.mem_d_ready = 1'b0; u_mem.mem_d_rvalid = 1'b0; u_mem.mem_d_rdata = 32'h0;

    repeat (2) tick();
    chk_reset_outputs("rst");
    rst_n = 1'b1;
    tick();

    // SW 0x100
    u_mem.mem_d_ready = 1'b1;
    issue(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF);
    chk("sw_mvalid", 32'(u_mem.mem_d_valid), 32'd1);
    chk("sw_mwe",    32'(u_mem.mem_d_we), 32'd1);
    chk("sw_maddr",  u_mem.mem_d_addr, 32'h100);
    chk("sw_mbe",    32'(u_mem.mem_d_be), 32'hF);
    chk("sw_mwdata", u_mem.mem_d_wdata, 32'hDEADBEEF);
    chk("sw_ready",  32'(u_req.req_ready), 32'd0);
    chk("sw_early",  32'(u_req.rsp_valid), 32'd0);
    tick();
    chk("sw_rsp_valid", 32'(u_req.rsp_valid), 32'd1);
    chk("sw_rsp_err",   32'(u_req.rsp_err), 32'd0);
    chk("sw_rdata",     u_req.rsp_rdata, 32'd0);
    chk("sw_mvalid_off", 32'(u_mem.mem_d_valid), 32'd0);
    tick();
    chk("sw_ready_back", 32'(u_req.req_ready), 32'd1);
    chk("sw_rsp_drop",   32'(u_req.rsp_valid), 32'd0);

    // SB 0x203
    issue(1'b1, 2'b00, 1'b0, 32'h203, 32'h123456A5);
    chk("sb_maddr",  u_mem.mem_d_addr, 32'h200);
    chk("sb_mbe",    32'(u_mem.mem_d_be), 32'h8);
    chk("sb_mwdata", u_mem.mem_d_wdata, 32'hA5A5A5A5);
    tick();
    chk("sb_rsp_valid", 32'(u_req.rsp_valid), 32'd1);
    tick();

    // Loads: byte signed/unsigned with slow read data, half signed/unsigned
    do_load("lb",  2'b00, 1'b0, 32'h101, 32'h123480FF, 2, 4'b0010, 32'hFFFFFF80);
    do_load("lbu", 2'b00, 1'b1, 32'h101, 32'h123480FF, 2, 4'b0010, 32'h00000080);
    do_load("lh",  2'b01, 1'b0, 32'h102, 32'h80017777, 1, 4'b1100, 32'hFFFF8001);
    do_load("lhu", 2'b01, 1'b1, 32'h102, 32'h80017777, 1, 4'b1100, 32'h00008001);
    do_load("lbu3",2'b00, 1'b1, 32'h207, 32'hC3000000, 1, 4'b1000, 32'h000000C3);
    do_load("lw",  2'b10, 1'b0, 32'h204, 32'hCAFEF00D, 1, 4'b1111, 32'hCAFEF00D);

    // Misaligned and illegal accesses
    do_err("lw_mis",  2'b10, 32'h102);
    do_err("lh_mis",  2'b01, 32'h101);
    do_err("illegal", 2'b11, 32'h100);

    // SH 0x206 with the bus stalled for 4 cycles
    u_mem.mem_d_ready = 1'b0;
    issue(1'b1, 2'b01, 1'b0, 32'h206, 32'h1234BEEF);
    for (int i = 0; i < 4; i++) begin
      chk("stall_mvalid", 32'(u_mem.mem_d_valid), 32'd1);
      chk("stall_maddr",  u_mem.mem_d_addr, 32'h204);
      chk("stall_mbe",    32'(u_mem.mem_d_be), 32'hC);
      chk("stall_mwdata", u_mem.mem_d_wdata, 32'hBEEFBEEF);
      chk("stall_ready",  32'(u_req.req_ready), 32'd0);
      chk("stall_rsp",    32'(u_req.rsp_valid), 32'd0);
      if (i == 1) begin
        u_req.req_valid = 1'b1; u_req.req_we = 1'b1; u_req.req_size = 2'b00;
        u_req.req_addr = 32'h301; u_req.req_wdata = 32'h00000077;
      end else begin
        u_req.req_valid = 1'b0;
      end
      tick();
    end
    u_req.req_valid = 1'b0;
    u_mem.mem_d_ready = 1'b1;
    chk("stall_end_mbe", 32'(u_mem.mem_d_be), 32'hC);
    tick();
    chk("stall_rsp_valid", 32'(u_req.rsp_valid), 32'd1);
    chk("stall_rsp_err",   32'(u_req.rsp_err), 32'd0);
    tick();
    chk("stall_ready_back", 32'(u_req.req_ready), 32'd1);
    chk("stall_no_extra",   32'(u_mem.mem_d_valid), 32'd0);
    tick();
    chk("stall_pulse_drop", 32'(u_mem.mem_d_valid), 32'd0);

    // Reset asserted while waiting for read data
    issue(1'b0, 2'b10, 1'b0, 32'h104, 32'h0);
    tick();
    chk("rstw_busy", 32'(u_req.req_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("rstw");
    tick();
    rst_n = 1'b1;
    u_mem.mem_d_rvalid = 1'b1;
    u_mem.mem_d_rdata  = 32'h0BADF00D;
    tick();
    u_mem.mem_d_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("rstw_no_rsp", 32'(u_req.rsp_valid), 32'd0);
      chk("rstw_idle",   32'(u_req.req_ready), 32'd1);
      tick();
    end
    issue(1'b1, 2'b10, 1'b0, 32'h400, 32'h55AA55AA);
    chk("post_sw_maddr",  u_mem.mem_d_addr, 32'h400);
    chk("post_sw_mwdata", u_mem.mem_d_wdata, 32'h55AA55AA);
    tick();
    chk("post_sw_rsp", 32'(u_req.rsp_valid), 32'd1);
    chk("post_sw_err", 32'(u_req.rsp_err), 32'd0);
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Execute-stage data-memory agent that carries out the load/store operations the decode stage requests. It accepts one request at a time (address, write data, access size, signedness), generates word-aligned bus cycles with byte enables and lane-replicated write data, and waits for the bus handshake. For loads, it extracts and sign- or zero-extends the addressed bytes. It returns a one-cycle response and holds `req_ready` low while a transaction is in flight, which stalls the pipeline.

## Interface
Parameters:
- `AW`, 32, address width
- `DW`, 32, data width; only 32 is supported

Ports:
- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `req_valid`  in  1  request present
- `req_ready`  out  1  block can accept a request; high only in IDLE
- `req_we`  in  1  1 = store, 0 = load
- `req_size`  in  2  access size: 2'b00 byte, 2'b01 half, 2'b10 word, 2'b11 illegal
- `req_unsigned`  in  1  load zero-extends when 1, sign-extends when 0; ignored for stores
- `req_addr`  in  AW  byte address
- `req_wdata`  in  DW  store data, right-justified
- `rsp_valid`  out  1  one-cycle completion pulse
- `rsp_err`  out  1  misaligned or illegal access; valid with `rsp_valid`
- `rsp_rdata`  out  DW  extended load data; 0 for stores and for errors
- `mem_d_valid`  out  1  bus request
- `mem_d_ready`  in  1  bus accepts the request
- `mem_d_we`  out  1  bus write
- `mem_d_addr`  out  AW  word-aligned address; `req_addr` with bits [1:0] forced to 0
- `mem_d_be`  out  4  byte enables
- `mem_d_wdata`  out  DW  lane-replicated store data
- `mem_d_rvalid`  in  1  read data valid
- `mem_d_rdata`  in  DW  read word

## Operation
- FSM states: IDLE, BUS_REQ, WAIT_RD, RESP.
- IDLE → accepts the request when `req_valid & req_ready`. All request fields are registered.
  - Misaligned or illegal access → RESP with error. No bus cycle is issued.
  - Otherwise → BUS_REQ.
- Misaligned access means any of:
  - half-word access with `addr[0]` = 1
  - word access with `addr[1:0]` != 0
  - `req_size` = 2'b11
- BUS_REQ: `mem_d_valid` = 1. `mem_d_addr`, `mem_d_be`, `mem_d_we` and `mem_d_wdata` stay stable until `mem_d_ready` is sampled high.
  - On accept, a store → RESP.
  - On accept, a load → WAIT_RD.
- WAIT_RD: waits for `mem_d_rvalid`, then captures `mem_d_rdata` → RESP. `mem_d_rvalid` is never honoured in the accept cycle itself.
- RESP: `rsp_valid` = 1 for exactly one cycle → IDLE.
- `mem_d_rvalid` is ignored in every state except WAIT_RD.
- Byte enables:
  - byte: 4'b0001 << `addr[1:0]`
  - half: 4'b0011 << (2·`addr[1]`)
  - word: 4'b1111
- Write data:
  - byte: `wdata[7:0]` replicated ×4
  - half: `wdata[15:0]` replicated ×2
  - word: unchanged
- Load data:
  - Shift the captured word right by 8·`addr[1:0]`.
  - Take bits [7:0] for a byte or [15:0] for a half.
  - Extend to 32 bits per `req_unsigned`.
  - A word load is returned unchanged.

## Timing
- Reset values:
  - state = IDLE, so `req_ready` = 1
  - `rsp_valid`, `rsp_err`, `mem_d_valid`, `mem_d_we` = 0
  - `mem_d_be` = 0
  - `mem_d_addr`, `mem_d_wdata`, `rsp_rdata` = 0
- Request accepted at cycle 0:
  - `mem_d_valid` rises at cycle 1.
  - Store with `mem_d_ready` = 1 at cycle 1 → `rsp_valid` at cycle 2.
  - Load with `mem_d_ready` = 1 at cycle 1 and `mem_d_rvalid` = 1 at cycle 2 → `rsp_valid` at cycle 3.
  - Error → `rsp_valid` with `rsp_err` at cycle 1.
- Back-to-back: `req_ready` is high again in the cycle after `rsp_valid`. Minimum request spacing is 3 cycles for stores and 4 for loads.
- `mem_d_ready` may stay low indefinitely; all bus outputs are held while it is low.
- `rsp_*` outputs are registered. `req_ready` is decoded from the state register.
- Reset asserted mid-transaction:
  - Takes effect immediately, asynchronously: `mem_d_valid` drops and no response is issued.
  - A stale `mem_d_rvalid` arriving after reset is ignored.

## Test plan
- Aligned store: SW, addr 0x100, wdata 0xDEADBEEF, `mem_d_ready` = 1 → `mem_d_addr` 0x100, `mem_d_be` 4'b1111, `mem_d_wdata` 0xDEADBEEF; `rsp_valid` 2 cycles after accept with `rsp_err` = 0, `rsp_rdata` = 0.
- Byte store: SB, addr 0x203, wdata 0x123456A5 → `mem_d_addr` 0x200, `mem_d_be` 4'b1000, `mem_d_wdata` 0xA5A5A5A5.
- Byte loads with slow read data: LB, addr 0x101, `mem_d_rdata` 0x123480FF, `mem_d_rvalid` 3 cycles after accept → `rsp_rdata` 0xFFFFFF80. The same access as LBU → 0x00000080.
- Half load and misaligned access:
  - LH, addr 0x102, `mem_d_rdata` 0x80017777 → `rsp_rdata` 0xFFFF8001.
  - LW, addr 0x102 → `rsp_err` = 1, `rsp_rdata` = 0 one cycle after accept, `mem_d_valid` never asserted.
- Bus stall: `mem_d_ready` held low for 4 cycles → `mem_d_valid`, address, `be` and `wdata` stable throughout; `req_ready` = 0; a `req_valid` pulse during the stall is not accepted.
- Reset in WAIT_RD: assert `rst_n` = 0 → all outputs return to reset values immediately; `mem_d_rvalid` after release produces no `rsp_valid`; the next SW completes normally.
